// File: rtl/hist_eq_pkg.sv
// hist_eq_pkg: shared FSM state type and counter-width helper for the histogram-equalisation sequencer
package hist_eq_pkg;
  typedef enum logic [2:0] {IDLE, CLEAR, WAIT_SOF, ACCUM, FLUSH, CDF, DONE} state_t;
  function automatic int cnt_w(input int width, input int height);
    return $clog2(width * height + 1);
  endfunction
endpackage

// File: rtl/hist_eq_frame_sequencer_if.sv
// hist_eq_frame_sequencer_if: pixel AXI-stream (tdata/tvalid/tlast=end of line/tuser=start of frame), no tready
interface hist_eq_frame_sequencer_if #(parameter int N = 8);
  logic [N-1:0] tdata;
  logic tvalid;
  logic tlast;
  logic tuser;
  modport master (output tdata, tvalid, tlast, tuser);
  modport slave (input tdata, tvalid, tlast, tuser);
endinterface

// File: rtl/hist_eq_rmw_pipe.sv
// hist_eq_rmw_pipe: two-stage histogram read-modify-write; i_v/i_addr = accepted beat, i_rdata = RAM read data, o_* = bin write
module hist_eq_rmw_pipe #(
  parameter int N = 8,
  parameter int CNT_W = 17
) (
  input  logic             i_sys_clk,
  input  logic             i_sys_areset,
  input  logic             i_v,
  input  logic [N-1:0]     i_addr,
  input  logic [CNT_W-1:0] i_rdata,
  output logic             o_we,
  output logic [N-1:0]     o_waddr,
  output logic [CNT_W-1:0] o_wdata
);
  logic s0_v_q, last_we_q;
  logic [N-1:0] s0_addr_q, last_addr_q;
  logic [CNT_W-1:0] last_data_q, bin;
  // The RAM is read-first, so a write in the previous cycle to the same bin is not yet visible in i_rdata.
  always_comb begin
    bin = (last_we_q && last_addr_q == s0_addr_q) ? last_data_q : i_rdata;
    o_we = s0_v_q;
    o_waddr = s0_v_q ? s0_addr_q : '0;
    o_wdata = s0_v_q ? bin + CNT_W'(1) : '0;
  end
  always_ff @(posedge i_sys_clk or posedge i_sys_areset)
    if (i_sys_areset) begin
      s0_v_q <= 1'b0;
      s0_addr_q <= '0;
      last_we_q <= 1'b0;
      last_addr_q <= '0;
      last_data_q <= '0;
    end else begin
      s0_v_q <= i_v;
      s0_addr_q <= i_addr;
      last_we_q <= s0_v_q;
      last_addr_q <= s0_addr_q;
      last_data_q <= o_wdata;
    end
endmodule

// File: rtl/hist_eq_frame_sequencer.sv
// hist_eq_frame_sequencer: per armed frame, clears the histogram, accumulates one frame, scans the CDF and writes the remap LUT.
// Ports: i_start arms a pass; reg_video is the pixel stream; o_hist_*/i_hist_rdata drive the read-first histogram RAM;
// o_lut_* write the LUT; o_busy/o_frame_done/o_err report status. Define HIST_EQ_FRAME_CHECK_EN for framing checks on o_err.
module hist_eq_frame_sequencer
  import hist_eq_pkg::*;
#(
  parameter int N = 8,
  parameter int WIDTH = 355,
  parameter int HEIGHT = 355,
  localparam int CNT_W = cnt_w(WIDTH, HEIGHT)
) (
  input  logic                    i_sys_clk,
  input  logic                    i_sys_areset,
  input  logic                    i_start,
  hist_eq_frame_sequencer_if.slave reg_video,
  output logic [N-1:0]            o_hist_raddr,
  input  logic [CNT_W-1:0]        i_hist_rdata,
  output logic [N-1:0]            o_hist_waddr,
  output logic                    o_hist_we,
  output logic [CNT_W-1:0]        o_hist_wdata,
  output logic [N-1:0]            o_lut_addr,
  output logic                    o_lut_we,
  output logic [N-1:0]            o_lut_wdata,
  output logic                    o_busy,
  output logic                    o_frame_done,
  output logic                    o_err
);
  localparam int DEPTH = 2 ** N;
  localparam int TOTAL = WIDTH * HEIGHT;
  state_t state_q;
  logic [N:0] idx_q;
  logic [CNT_W-1:0] pix_q, pix_d, cdf_q, cdf_sum, rmw_wdata;
  logic [CNT_W+N-1:0] prod;
  logic accept, rmw_we;
  logic [N-1:0] rmw_waddr;
  hist_eq_rmw_pipe #(.N(N), .CNT_W(CNT_W)) u_rmw (
    .i_sys_clk(i_sys_clk),
    .i_sys_areset(i_sys_areset),
    .i_v(accept),
    .i_addr(reg_video.tdata),
    .i_rdata(i_hist_rdata),
    .o_we(rmw_we),
    .o_waddr(rmw_waddr),
    .o_wdata(rmw_wdata)
  );
  // In CDF, idx_q runs 0..DEPTH: it addresses bin idx_q and the LUT entry one behind it.
  always_comb begin
    accept = reg_video.tvalid && ((state_q == WAIT_SOF && reg_video.tuser) || state_q == ACCUM);
    pix_d = pix_q + CNT_W'(1);
    cdf_sum = cdf_q + i_hist_rdata;
    prod = (CNT_W+N)'(cdf_sum) * (CNT_W+N)'(DEPTH - 1);
    o_hist_raddr = state_q == CDF ? idx_q[N-1:0] : accept ? reg_video.tdata : '0;
    o_hist_we = state_q == CLEAR || rmw_we;
    o_hist_waddr = state_q == CLEAR ? idx_q[N-1:0] : rmw_waddr;
    o_hist_wdata = rmw_wdata;
    o_lut_we = state_q == CDF && idx_q != '0;
    o_lut_addr = o_lut_we ? N'(idx_q - 1'b1) : '0;
    o_lut_wdata = o_lut_we ? N'(prod / (CNT_W+N)'(TOTAL)) : '0;
  end
`ifdef HIST_EQ_FRAME_CHECK_EN
  logic [CNT_W-1:0] col_q;
`else
  logic unused_tlast;
  assign unused_tlast = reg_video.tlast;
  assign o_err = 1'b0;
`endif
  always_ff @(posedge i_sys_clk or posedge i_sys_areset)
    if (i_sys_areset) begin
      state_q <= IDLE;
      idx_q <= '0;
      pix_q <= '0;
      cdf_q <= '0;
      o_busy <= 1'b0;
      o_frame_done <= 1'b0;
`ifdef HIST_EQ_FRAME_CHECK_EN
      col_q <= '0;
      o_err <= 1'b0;
`endif
    end else begin
      o_frame_done <= 1'b0;
      case (state_q)
        IDLE: if (i_start) begin
          state_q <= CLEAR;
          idx_q <= '0;
          pix_q <= '0;
          o_busy <= 1'b1;
`ifdef HIST_EQ_FRAME_CHECK_EN
          col_q <= '0;
          o_err <= 1'b0;
`endif
        end
        CLEAR: begin
          idx_q <= idx_q + 1'b1;
          if (idx_q == (N+1)'(DEPTH - 1)) state_q <= WAIT_SOF;
        end
        WAIT_SOF, ACCUM: if (accept) begin
          pix_q <= pix_d;
          state_q <= pix_d == CNT_W'(TOTAL) ? FLUSH : ACCUM;
`ifdef HIST_EQ_FRAME_CHECK_EN
          if (reg_video.tlast != (col_q == CNT_W'(WIDTH - 1)) || (state_q == ACCUM && reg_video.tuser)) o_err <= 1'b1;
          col_q <= col_q == CNT_W'(WIDTH - 1) ? '0 : col_q + CNT_W'(1);
`endif
        end
        FLUSH: begin
          state_q <= CDF;
          idx_q <= '0;
          cdf_q <= '0;
        end
        CDF: begin
          idx_q <= idx_q + 1'b1;
          if (idx_q != '0) cdf_q <= cdf_sum;
          if (idx_q == (N+1)'(DEPTH)) begin
            state_q <= DONE;
            o_frame_done <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          o_busy <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_hist_eq_frame_sequencer.sv
// tb_hist_eq_frame_sequencer: randomized frames against a counting/CDF reference model with a LUT-write scoreboard
module tb_hist_eq_frame_sequencer;
  localparam int N = 8;
  localparam int W = 4;
  localparam int H = 2;
  localparam int CW = 4;
  localparam int TOTAL = W * H;
`ifdef HIST_EQ_FRAME_CHECK_EN
  localparam bit EXP_ERR = 1'b1;
`else
  localparam bit EXP_ERR = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [N-1:0] raddr, waddr, lut_addr, lut_wdata;
  logic [CW-1:0] rdata = '0, wdata;
  logic we, lut_we, busy, frame_done, err;
  logic [CW-1:0] hist_mem [256];
  int total = 0, bad = 0, cyc = 0;
  int exp_addr_q[$], exp_data_q[$], done_q[$];
  int ref_hist[256];
  int fp[8];
  int ea, ed, dc;
  hist_eq_frame_sequencer_if #(.N(N)) vid();
  hist_eq_frame_sequencer #(.N(N), .WIDTH(W), .HEIGHT(H)) dut (
    .i_sys_clk(clk),
    .i_sys_areset(rst),
    .i_start(start),
    .reg_video(vid),
    .o_hist_raddr(raddr),
    .i_hist_rdata(rdata),
    .o_hist_waddr(waddr),
    .o_hist_we(we),
    .o_hist_wdata(wdata),
    .o_lut_addr(lut_addr),
    .o_lut_we(lut_we),
    .o_lut_wdata(lut_wdata),
    .o_busy(busy),
    .o_frame_done(frame_done),
    .o_err(err)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    rdata <= hist_mem[raddr];
    if (we) hist_mem[waddr] <= wdata;
  end
  task automatic check(input string nm, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d (t=%0t)", nm, act, exp, $time);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk)
    if (!rst) begin
      if (lut_we) begin
        check("lut_write_expected", exp_addr_q.size() != 0, 1);
        if (exp_addr_q.size() != 0) begin
          ea = exp_addr_q.pop_front();
          ed = exp_data_q.pop_front();
          check("lut_addr", lut_addr, ea);
          check($sformatf("lut_data[%0d]", ea), lut_wdata, ed);
        end
      end
      if (frame_done) begin
        check("done_expected", done_q.size() != 0, 1);
        if (done_q.size() != 0) begin
          dc = done_q.pop_front();
          check("done_cycle", cyc, dc);
        end
      end
    end
  task automatic arm_and_wait(input bit junk);
    start = 1'b1;
    step();
    start = 1'b0;
    check("busy_after_start", busy, 1);
    check("err_after_start", err, 0);
    for (int j = 0; j < 258; j++) begin
      vid.tvalid = junk && j[0];
      vid.tdata = 8'd99;
      vid.tuser = 1'b0;
      vid.tlast = 1'b0;
      step();
    end
    vid.tvalid = 1'b0;
  endtask
  task automatic run_frame(input int gap_max, input bit bad_tlast, input bit poke, input bit junk);
    int cdf;
    int n;
    arm_and_wait(junk);
    ref_hist = '{default: 0};
    foreach (fp[i]) ref_hist[fp[i]]++;
    cdf = 0;
    for (int k = 0; k < 256; k++) begin
      cdf += ref_hist[k];
      exp_addr_q.push_back(k);
      exp_data_q.push_back(cdf * 255 / TOTAL);
    end
    for (int i = 0; i < 8; i++) begin
      if (i > 0 && gap_max > 0) begin
        vid.tvalid = 1'b0;
        start = 1'b0;
        repeat ($urandom_range(0, gap_max)) step();
      end
      vid.tvalid = 1'b1;
      vid.tdata = 8'(fp[i]);
      vid.tuser = i == 0;
      vid.tlast = bad_tlast ? (i == 2) : (i % W == W - 1);
      start = poke;
      if (i == 7) done_q.push_back(cyc + 259);
      step();
    end
    vid.tvalid = 1'b0;
    vid.tuser = 1'b0;
    vid.tlast = 1'b0;
    start = 1'b0;
    n = 0;
    while (exp_addr_q.size() + done_q.size() != 0 && n < 700) begin
      step();
      n++;
    end
    check("drain_in_time", n < 700, 1);
    exp_addr_q.delete();
    exp_data_q.delete();
    done_q.delete();
    step();
    check("busy_idle", busy, 0);
    for (int k = 0; k < 256; k++) check($sformatf("hist[%0d]", k), hist_mem[k], ref_hist[k]);
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
  initial begin
    vid.tvalid = 1'b0;
    vid.tdata = '0;
    vid.tuser = 1'b0;
    vid.tlast = 1'b0;
    repeat (3) step();
    check("rst_busy", busy, 0);
    check("rst_done", frame_done, 0);
    check("rst_err", err, 0);
    check("rst_hist_we", we, 0);
    check("rst_lut_we", lut_we, 0);
    rst = 1'b0;
    step();
    fp = '{10, 10, 10, 10, 10, 10, 10, 10};
    run_frame(0, 0, 0, 0);
    fp = '{0, 255, 0, 255, 0, 255, 0, 255};
    run_frame(3, 0, 0, 0);
    fp = '{5, 5, 7, 5, 5, 5, 7, 7};
    run_frame(0, 0, 0, 0);
    arm_and_wait(0);
    for (int i = 0; i < 3; i++) begin
      vid.tvalid = 1'b1;
      vid.tdata = 8'd10;
      vid.tuser = i == 0;
      vid.tlast = 1'b0;
      step();
    end
    #3 rst = 1'b1;
    #1;
    check("arst_busy", busy, 0);
    check("arst_hist_we", we, 0);
    check("arst_raddr", raddr, 0);
    check("arst_lut_we", lut_we, 0);
    check("arst_done", frame_done, 0);
    vid.tvalid = 1'b0;
    vid.tuser = 1'b0;
    step();
    rst = 1'b0;
    step();
    fp = '{10, 10, 10, 10, 10, 10, 10, 10};
    run_frame(0, 0, 0, 0);
    foreach (fp[i]) fp[i] = $urandom_range(0, 255);
    run_frame(0, 1, 0, 0);
    check("err_sticky_after_done", err, EXP_ERR);
    foreach (fp[i]) fp[i] = $urandom_range(0, 255);
    run_frame(1, 0, 0, 0);
    check("err_clean_frame", err, 0);
    fp = '{5, 5, 7, 5, 5, 5, 7, 7};
    run_frame(0, 0, 1, 1);
    for (int r = 0; r < 4; r++) begin
      foreach (fp[i]) fp[i] = 40 + $urandom_range(0, 2);
      run_frame(r[0] ? 2 : 0, 0, 0, 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
